// File: rtl/clkgate_arb.sv
// Round-robin arbiter that hands a gated clock to one requester for a counted burst.
// Every output is a flop, so a downstream clkgate sees a glitch-free, edge-aligned gate.
module clkgate_arb #(
  parameter int REQS = 2,
  parameter int LENW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQS-1:0]      req,
  input  logic [REQS*LENW-1:0] len,
  output logic [REQS-1:0]      grant,
  output logic                 gate,
  output logic                 busy,
  output logic [REQS-1:0]      done,
  output logic [1:0]           state_dbg
);

  localparam int OW = (REQS > 1) ? $clog2(REQS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]      state;
  logic [LENW-1:0] cnt;
  logic [OW-1:0]   last_owner;

  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic [LENW-1:0] win_len;

  function automatic logic [REQS-1:0] onehot(input logic [OW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Search upward from the previous owner so the last winner ranks lowest.
  always_comb begin
    int            idx;
    int            base;
    logic [OW-1:0] cand;
    win_found = 1'b0;
    win_idx   = last_owner;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= REQS; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= REQS) idx = idx - REQS;
      cand = OW'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    base    = int'(win_idx) * LENW;
    win_len = len[base +: LENW];
  end

  // cnt holds the remaining pulses after the current one; gate falls when it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= OW'(REQS - 1);
      grant      <= '0;
      gate       <= 1'b0;
      busy       <= 1'b0;
      done       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (win_found) begin
            last_owner <= win_idx;
            busy       <= 1'b1;
            if (win_len != '0) begin
              cnt   <= win_len - 1'b1;
              grant <= onehot(win_idx);
              gate  <= 1'b1;
              state <= RUN;
            end else begin
              cnt   <= '0;
              done  <= onehot(win_idx);
              state <= GAP;
            end
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            gate  <= 1'b0;
            grant <= '0;
            done  <= onehot(last_owner);
            state <= GAP;
          end
        end
        GAP: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          gate  <= 1'b0;
          busy  <= 1'b0;
          done  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
